// File: rtl/component_stream_mux_pkg.sv
// Shared types and helpers for the component stream multiplexer.
// Holds the record layout, the default field width and the FIFO pointer-width rule.
package component_stream_mux_pkg;

    localparam int VAL_W_DEF = 64;

    typedef struct packed {
        logic [VAL_W_DEF-1:0] val;
        logic [VAL_W_DEF-1:0] size_of_bit;
        logic                 flush;
    } stream_rec_t;

    // One extra bit beyond the address so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/component_stream_mux_if.sv
// Handshake bundle between component producers, the multiplexer and the bitstream writer.
// master = surrounding logic (producers + writer), slave = the multiplexer.
interface component_stream_mux_if #(
    parameter int NUM_CH = 3,
    parameter int VAL_W  = 64
);
    logic [NUM_CH-1:0]            in_enable;
    logic [NUM_CH-1:0][VAL_W-1:0] in_val;
    logic [NUM_CH-1:0][VAL_W-1:0] in_size_of_bit;
    logic [NUM_CH-1:0]            in_flush;
    logic [NUM_CH-1:0]            in_ready;

    logic                         sb_enable;
    logic [VAL_W-1:0]             sb_val;
    logic [VAL_W-1:0]             sb_size_of_bit;
    logic                         sb_flush;
    logic                         sb_ready;
    logic                         slice_done;

    modport master (
        output in_enable, in_val, in_size_of_bit, in_flush, sb_ready,
        input  in_ready, sb_enable, sb_val, sb_size_of_bit, sb_flush, slice_done
    );

    modport slave (
        input  in_enable, in_val, in_size_of_bit, in_flush, sb_ready,
        output in_ready, sb_enable, sb_val, sb_size_of_bit, sb_flush, slice_done
    );
endinterface

// File: rtl/component_record_fifo.sv
// Single-channel synchronous record FIFO with show-ahead head and push-while-full
// support when the same edge pops.
module component_record_fifo
    import component_stream_mux_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 129
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/component_stream_mux.sv
// Merges per-component record streams into one bitstream-writer stream in channel order.
// Optional build macro COMPONENT_STREAM_MUX_BITCOUNT_EN adds a per-slice bit total on slice_bits.
module component_stream_mux
    import component_stream_mux_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int VAL_W      = VAL_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    component_stream_mux_if.slave      bus
`ifdef COMPONENT_STREAM_MUX_BITCOUNT_EN
    ,
    output logic [31:0]                slice_bits
`endif
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REC_W = 2 * VAL_W + 1;

    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_push;
    logic [NUM_CH-1:0] fifo_pop;
    logic [REC_W-1:0]  fifo_head [NUM_CH];
    logic [REC_W-1:0]  head;
    logic              head_valid;
    logic              pop_req;
    logic              last_ch;
    logic              slice_done_q;

    // Record layout in the FIFO mirrors stream_rec_t: {val, size_of_bit, flush}.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign fifo_push[c] = bus.in_enable[c] && bus.in_ready[c] &&
                              ((bus.in_size_of_bit[c] != '0) || bus.in_flush[c]);
        assign fifo_pop[c]  = pop_req && (ch == CH_W'(c));
        assign bus.in_ready[c] = !fifo_full[c] || fifo_pop[c];

        component_record_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (REC_W)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (clear),
            .push    (fifo_push[c]),
            .pop     (fifo_pop[c]),
            .wdata   ({bus.in_val[c], bus.in_size_of_bit[c], bus.in_flush[c]}),
            .rdata   (fifo_head[c]),
            .empty   (fifo_empty[c]),
            .full    (fifo_full[c])
        );
    end

    always_comb begin
        head       = '0;
        head_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) begin
                head       = fifo_head[c];
                head_valid = !fifo_empty[c];
            end
        end
    end

    assign pop_req  = head_valid && bus.sb_ready;
    assign last_ch  = (ch == CH_W'(NUM_CH - 1));

    assign bus.sb_enable = head_valid;
    assign {bus.sb_val, bus.sb_size_of_bit, bus.sb_flush} = head_valid ? head : '0;
    assign bus.slice_done = slice_done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ch           <= '0;
            slice_done_q <= 1'b0;
        end else if (clear) begin
            ch           <= '0;
            slice_done_q <= 1'b0;
        end else begin
            slice_done_q <= pop_req && head[0] && last_ch;
            if (pop_req && head[0]) ch <= last_ch ? '0 : ch + CH_W'(1);
        end
    end

`ifdef COMPONENT_STREAM_MUX_BITCOUNT_EN
    logic [31:0] bit_acc;
    logic [31:0] head_bits;

    assign head_bits = 32'(head[VAL_W:1]);

    // The accumulator restarts on the popping edge so a record popped during
    // the slice_done cycle already counts toward the next slice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_acc    <= '0;
            slice_bits <= '0;
        end else if (clear) begin
            bit_acc    <= '0;
            slice_bits <= '0;
        end else if (pop_req) begin
            if (head[0] && last_ch) begin
                slice_bits <= bit_acc + head_bits;
                bit_acc    <= '0;
            end else begin
                bit_acc    <= bit_acc + head_bits;
            end
        end
    end
`endif

endmodule

// File: tb/tb_component_stream_mux.sv
// Self-checking bench for component_stream_mux: table-driven pushes plus a
// channel-ordered scoreboard that checks every presented and popped record.
module tb_component_stream_mux;
    import component_stream_mux_pkg::*;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int VW    = 64;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;

    component_stream_mux_if #(.NUM_CH(NCH), .VAL_W(VW)) bus_if ();

`ifdef COMPONENT_STREAM_MUX_BITCOUNT_EN
    logic [31:0] slice_bits;
`endif

    component_stream_mux #(
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .VAL_W      (VW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus_if)
`ifdef COMPONENT_STREAM_MUX_BITCOUNT_EN
        ,
        .slice_bits (slice_bits)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          ch;
        logic [63:0] val;
        logic [63:0] size;
        logic        flush;
        logic        rdy;
        logic        exp_ready;
    } vec_t;

    vec_t        tbl [$];
    stream_rec_t q [NCH][$];
    int          mch;
    bit          exp_sd;
    bit          mon_en;
    int          n_cmp;
    int          n_bad;
    int          pop_count;
    int          sd_count;

    stream_rec_t       m_head;
    stream_rec_t       m_rec;
    bit                m_en;
    bit                m_pop;
    logic [NCH-1:0]    m_rdy;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Scoreboard: compare the state left by the last edge, then fold in the
    // inputs that the coming edge will act on.
    always @(negedge clock) begin
        if (mon_en) begin
            m_en = (q[mch].size() != 0);
            chk("sb_enable", bus_if.sb_enable, m_en);
            if (m_en) begin
                m_head = q[mch][0];
                chk("sb_val", bus_if.sb_val, m_head.val);
                chk("sb_size_of_bit", bus_if.sb_size_of_bit, m_head.size_of_bit);
                chk("sb_flush", bus_if.sb_flush, m_head.flush);
            end else begin
                chk("sb_val_idle", bus_if.sb_val, 64'd0);
                chk("sb_size_idle", bus_if.sb_size_of_bit, 64'd0);
                chk("sb_flush_idle", bus_if.sb_flush, 64'd0);
            end
            chk("slice_done", bus_if.slice_done, exp_sd);
            if (bus_if.slice_done) sd_count++;

            m_pop = m_en && bus_if.sb_ready;
            for (int c = 0; c < NCH; c++)
                m_rdy[c] = (q[c].size() < DEPTH) || (m_pop && (c == mch));
            chk("in_ready", bus_if.in_ready, m_rdy);

            if (clear) begin
                for (int c = 0; c < NCH; c++) q[c].delete();
                mch    = 0;
                exp_sd = 1'b0;
            end else begin
                exp_sd = 1'b0;
                if (m_pop) begin
                    m_head = q[mch].pop_front();
                    pop_count++;
                    if (m_head.flush) begin
                        exp_sd = (mch == NCH - 1);
                        mch    = (mch + 1) % NCH;
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    if (bus_if.in_enable[c] && m_rdy[c] &&
                        ((bus_if.in_size_of_bit[c] != '0) || bus_if.in_flush[c])) begin
                        m_rec.val         = bus_if.in_val[c];
                        m_rec.size_of_bit = bus_if.in_size_of_bit[c];
                        m_rec.flush       = bus_if.in_flush[c];
                        q[c].push_back(m_rec);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus_if.in_enable = '0;
    endtask

    task automatic drive(input int c, input logic [63:0] v, input logic [63:0] s, input logic f);
        bus_if.in_enable          = '0;
        bus_if.in_enable[c]       = 1'b1;
        bus_if.in_val[c]          = v;
        bus_if.in_size_of_bit[c]  = s;
        bus_if.in_flush[c]        = f;
    endtask

    task automatic add(input int c, input logic [63:0] v, input logic [63:0] s,
                       input logic f, input logic r, input logic er);
        vec_t e;
        e.ch = c; e.val = v; e.size = s; e.flush = f; e.rdy = r; e.exp_ready = er;
        tbl.push_back(e);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            drive(tbl[i].ch, tbl[i].val, tbl[i].size, tbl[i].flush);
            bus_if.sb_ready = tbl[i].rdy;
            #1;
            chk("tbl_in_ready", bus_if.in_ready[tbl[i].ch], tbl[i].exp_ready);
            tick();
        end
        idle();
        tbl.delete();
    endtask

    task automatic wait_slice_done(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus_if.slice_done) found = 1'b1;
            else tick();
        end
        chk(name, found, 1'b1);
    endtask

    int p0;
    int sd0;

    initial begin
        bus_if.in_enable      = '0;
        bus_if.in_val         = '0;
        bus_if.in_size_of_bit = '0;
        bus_if.in_flush       = '0;
        bus_if.sb_ready       = 1'b0;
        mch = 0; exp_sd = 1'b0; mon_en = 1'b0;
        n_cmp = 0; n_bad = 0; pop_count = 0; sd_count = 0;

        #12;
        chk("rst_in_ready", bus_if.in_ready, 3'b111);
        chk("rst_sb_enable", bus_if.sb_enable, 1'b0);
        chk("rst_sb_val", bus_if.sb_val, 64'd0);
        chk("rst_sb_size", bus_if.sb_size_of_bit, 64'd0);
        chk("rst_sb_flush", bus_if.sb_flush, 1'b0);
        chk("rst_slice_done", bus_if.slice_done, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // Single record, one-cycle latency.
        drive(0, 64'h5, 64'd3, 1'b0);
        bus_if.sb_ready = 1'b1;
        tick();
        idle();
        chk("lat_sb_enable", bus_if.sb_enable, 1'b1);
        chk("lat_sb_val", bus_if.sb_val, 64'h5);
        chk("lat_sb_size", bus_if.sb_size_of_bit, 64'd3);
        tick();
        chk("lat_drained", bus_if.sb_enable, 1'b0);

        // Reverse arrival order, discard of an empty non-flush record.
        bus_if.sb_ready = 1'b0;
        add(2, 64'h21, 64'd4, 1'b0, 1'b0, 1'b1);
        add(2, 64'h22, 64'd5, 1'b0, 1'b0, 1'b1);
        add(2, 64'h23, 64'd6, 1'b1, 1'b0, 1'b1);
        add(1, 64'h11, 64'd7, 1'b0, 1'b0, 1'b1);
        add(1, 64'h12, 64'd8, 1'b0, 1'b0, 1'b1);
        add(1, 64'h13, 64'd9, 1'b1, 1'b0, 1'b1);
        add(0, 64'h01, 64'd0, 1'b0, 1'b0, 1'b1);
        add(0, 64'h02, 64'd3, 1'b0, 1'b0, 1'b1);
        add(0, 64'h03, 64'd2, 1'b0, 1'b0, 1'b1);
        add(0, 64'h04, 64'd0, 1'b1, 1'b0, 1'b1);
        run_table();
        chk("order_head_ch0", bus_if.sb_val, 64'h02);
        sd0 = sd_count;
        bus_if.sb_ready = 1'b1;
        wait_slice_done("order_slice_done_seen");
        repeat (3) tick();
        chk("order_slice_done_once", sd_count - sd0, 1);
        chk("order_drained", bus_if.sb_enable, 1'b0);

        // Fill to full; fifth push refused; drain exactly four.
        add(0, 64'h100, 64'd1, 1'b0, 1'b0, 1'b1);
        add(0, 64'h101, 64'd2, 1'b0, 1'b0, 1'b1);
        add(0, 64'h102, 64'd3, 1'b0, 1'b0, 1'b1);
        add(0, 64'h103, 64'd4, 1'b0, 1'b0, 1'b1);
        add(0, 64'h104, 64'd5, 1'b0, 1'b0, 1'b0);
        run_table();
        bus_if.sb_ready = 1'b0;
        #1;
        chk("full_in_ready", bus_if.in_ready[0], 1'b0);
        p0 = pop_count;
        bus_if.sb_ready = 1'b1;
        repeat (6) tick();
        chk("full_drain_count", pop_count - p0, 4);
        chk("full_drained", bus_if.sb_enable, 1'b0);

        // Full FIFO with push and pop on every edge for ten cycles.
        add(0, 64'h200, 64'd1, 1'b0, 1'b0, 1'b1);
        add(0, 64'h201, 64'd1, 1'b0, 1'b0, 1'b1);
        add(0, 64'h202, 64'd1, 1'b0, 1'b0, 1'b1);
        add(0, 64'h203, 64'd1, 1'b0, 1'b0, 1'b1);
        run_table();
        p0 = pop_count;
        for (int i = 0; i < 10; i++) begin
            drive(0, 64'h300 + 64'(i), 64'd8, 1'b0);
            bus_if.sb_ready = 1'b1;
            #1;
            chk("ovl_in_ready", bus_if.in_ready[0], 1'b1);
            tick();
        end
        idle();
        bus_if.sb_ready = 1'b0;
        #1;
        chk("ovl_still_full", bus_if.in_ready[0], 1'b0);
        bus_if.sb_ready = 1'b1;
        repeat (6) tick();
        chk("ovl_pop_total", pop_count - p0, 14);
        chk("ovl_drained", bus_if.sb_enable, 1'b0);

        // Clear while channel 1 holds three records.
        drive(0, 64'h0, 64'd0, 1'b1);
        bus_if.sb_ready = 1'b1;
        tick();
        idle();
        tick();
        bus_if.sb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h400 + 64'(i), 64'd2, 1'b0);
            tick();
        end
        idle();
        chk("clr_pre_enable", bus_if.sb_enable, 1'b1);
        chk("clr_pre_val", bus_if.sb_val, 64'h400);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_sb_enable", bus_if.sb_enable, 1'b0);
        chk("clr_in_ready", bus_if.in_ready, 3'b111);
        chk("clr_slice_done", bus_if.slice_done, 1'b0);
        bus_if.in_enable            = 3'b011;
        bus_if.in_val[0]            = 64'h500;
        bus_if.in_size_of_bit[0]    = 64'd1;
        bus_if.in_flush[0]          = 1'b0;
        bus_if.in_val[1]            = 64'h600;
        bus_if.in_size_of_bit[1]    = 64'd1;
        bus_if.in_flush[1]          = 1'b0;
        tick();
        idle();
        chk("clr_ch_reset", bus_if.sb_val, 64'h500);
        bus_if.sb_ready = 1'b1;
        repeat (2) tick();
        chk("clr_ch1_waits", bus_if.sb_enable, 1'b0);
        bus_if.sb_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;

`ifdef COMPONENT_STREAM_MUX_BITCOUNT_EN
        add(0, 64'h1, 64'd3,  1'b0, 1'b0, 1'b1);
        add(0, 64'h2, 64'd5,  1'b1, 1'b0, 1'b1);
        add(1, 64'h3, 64'd64, 1'b1, 1'b0, 1'b1);
        add(2, 64'h4, 64'd7,  1'b1, 1'b0, 1'b1);
        run_table();
        bus_if.sb_ready = 1'b1;
        wait_slice_done("bits_slice_done_seen");
        chk("slice_bits", slice_bits, 32'd79);
        repeat (2) tick();
`endif

        bus_if.sb_ready = 1'b0;
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/component_stream_mux.md
COMPONENT_STREAM_MUX -- requirements
Module: component_stream_mux

Interface
REQ-001 Parameter NUM_CH, default 3, number of component channels (Y, Cb, Cr); legal range 1..8.
REQ-002 Parameter FIFO_DEPTH, default 16, records per channel FIFO; SHALL be a power of two, 4..64.
REQ-003 Parameter VAL_W, default 64, width of val and size_of_bit fields.
REQ-004 clock  input  1  single clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous clear of all FIFOs, counters and the channel pointer.
REQ-007 in_enable  input  NUM_CH  per-channel record strobe.
REQ-008 in_val  input  NUM_CH x VAL_W  per-channel codeword bits.
REQ-009 in_size_of_bit  input  NUM_CH x VAL_W  per-channel codeword length in bits.
REQ-010 in_flush  input  NUM_CH  per-channel end-of-component marker.
REQ-011 in_ready  output  NUM_CH  per-channel FIFO not full.
REQ-012 sb_enable  output  1  output record valid.
REQ-013 sb_val, sb_size_of_bit  output  VAL_W each  output record fields.
REQ-014 sb_flush  output  1  output end-of-component marker.
REQ-015 sb_ready  input  1  bitstream writer accepts the record this cycle.
REQ-016 slice_done  output  1  one-cycle pulse after the last channel's flush record is accepted.

Function
REQ-017 A record SHALL be written into channel c's FIFO when in_enable[c] and in_ready[c] are both high; in_ready[c] = not full.
REQ-018 A record with in_enable high, in_size_of_bit zero and in_flush low SHALL be discarded and not written.
REQ-019 The block SHALL hold a channel pointer ch, reset 0, and present only FIFO[ch]'s head on the sb_* outputs.
REQ-020 sb_enable SHALL be high when FIFO[ch] is non-empty; sb_* outputs SHALL be zero when sb_enable is low.
REQ-021 A record SHALL be popped when sb_enable and sb_ready are both high; sb_* SHALL hold stable while sb_enable is high and sb_ready is low.
REQ-022 Minimum latency SHALL be one cycle: a record written at edge N SHALL be presentable on sb_* after edge N.
REQ-023 Popping a record with flush set SHALL advance ch to ch+1, wrapping from NUM_CH-1 to 0 on the same edge.
REQ-024 slice_done SHALL pulse for one cycle on the cycle after the edge that pops channel NUM_CH-1's flush record.
REQ-025 Simultaneous push and pop on the same FIFO SHALL be legal, including when the FIFO is full (occupancy unchanged) or empty (pop suppressed, push lands).
REQ-026 Non-selected channels SHALL keep accepting records until full; their records SHALL never be emitted out of channel order.
REQ-027 clear SHALL take priority over push and pop on the same edge; all FIFOs become empty, ch = 0, and slice_done is not pulsed.
REQ-028 FIFO read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH to distinguish full from empty.

Reset
REQ-029 While reset_n is low, FIFOs SHALL be empty, ch = 0, in_ready = all ones, sb_enable = 0, sb_val = 0, sb_size_of_bit = 0, sb_flush = 0, and slice_done = 0.
REQ-030 Assertion mid-record SHALL discard all buffered records; reset release SHALL be synchronised by the parent.

Configuration
REQ-031 Macro COMPONENT_STREAM_MUX_BITCOUNT_EN defined: the block SHALL add output slice_bits (32 bits), accumulate sb_size_of_bit of every popped record modulo 2^32, and latch the total on the slice_done cycle, with the accumulator zeroed by reset, clear and slice_done.
REQ-032 Macro absent: slice_bits and the accumulator SHALL not exist; all other behaviour is identical.

Structure
REQ-033 A shared package SHALL hold the record struct {val, size_of_bit, flush}, VAL_W default and the pointer-width function.
REQ-034 One sub-module, component_record_fifo (single-channel synchronous FIFO), SHALL be instantiated NUM_CH times.

Verification
REQ-035 Single record on channel 0 with val=0x5, size=3, sb_ready=1 -> sb_enable high one cycle later with val 0x5 and size 3.
REQ-036 Three channels, each sending 2 records then a flush, in reverse arrival order 2,1,0 -> output order is ch0, ch1, ch2, and slice_done pulses once after ch2's flush.
REQ-037 FIFO_DEPTH=4, sb_ready=0, push 4 records on ch0 -> in_ready[0]=0 after the 4th; a 5th push is ignored; raising sb_ready drains exactly 4 records in order.
REQ-038 Full FIFO with simultaneous push and pop over 10 cycles -> occupancy stays 4 and no record is lost or duplicated.
REQ-039 clear asserted while ch=1 holds 3 records -> next cycle sb_enable=0, ch=0, in_ready all ones, and no slice_done.
REQ-040 With BITCOUNT_EN, slice records of sizes 3+5+64+7 with flushes -> slice_bits=79 on the slice_done cycle.
